// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared FSM state type and scheduling mode encodings
package demux_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic MODE_DEST = 1'b0;
  localparam logic MODE_RR   = 1'b1;

endpackage

// File: rtl/demux_out_reg.sv
// rtl/demux_out_reg.sv - one-entry output holding register with one-hot channel valid
module demux_out_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              load_sel,
  input  logic [DATA_W-1:0] load_data,
  input  logic              sel,
  input  logic [1:0]        out_ready,
  output logic [1:0]        out_valid,
  output logic [DATA_W-1:0] out_data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 2'b00;
      out_data  <= '0;
    end else if (load) begin
      out_data  <= load_data;
      out_valid <= {load_sel, ~load_sel};
    end else if (out_valid[sel] & out_ready[sel]) begin
      out_valid <= 2'b00;
    end
  end

endmodule

// File: rtl/demux_burst_sched.sv
// rtl/demux_burst_sched.sv - burst scheduler locking the demux select for whole fixed-length bursts
module demux_burst_sched
  import demux_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_dest,
  output logic [1:0]        out_valid,
  input  logic [1:0]        out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              sel,
  output logic              busy
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             rr_ptr, rr_ptr_n;
  logic             sel_n;
  logic             load_sel;
  logic             accept;

  // The held word blocks new input unless it drains this same cycle.
  assign in_ready = ~|out_valid | out_ready[sel];
  assign accept   = in_valid & in_ready;
  assign busy     = (state == BURST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      rr_ptr <= 1'b0;
      sel    <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      rr_ptr <= rr_ptr_n;
      sel    <= sel_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    rr_ptr_n = rr_ptr;
    sel_n    = sel;
    load_sel = sel;
    case (state)
      IDLE: begin
        if (accept) begin
          if (mode == MODE_RR) begin
            load_sel = rr_ptr;
            rr_ptr_n = ~rr_ptr;
          end else begin
            load_sel = in_dest;
          end
          sel_n = load_sel;
          if (BURST_LEN > 1) begin
            state_n = BURST;
            cnt_n   = CNT_W'(1);
          end
        end
      end
      BURST: begin
        if (accept) begin
          if (cnt == LAST) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  demux_out_reg #(
    .DATA_W(DATA_W)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_sel (load_sel),
    .load_data(in_data),
    .sel      (sel),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data)
  );

endmodule

// File: tb/tb_demux_burst_sched.sv
// tb/tb_demux_burst_sched.sv - directed self-checking bench for demux_burst_sched
module tb_demux_burst_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode, in_valid, in_dest;
  logic [7:0] in_data;
  logic [1:0] out_ready;
  logic       in_ready, sel, busy;
  logic [1:0] out_valid;
  logic [7:0] out_data;

  logic       b_mode, b_valid, b_dest;
  logic [7:0] b_data;
  logic [1:0] b_out_ready;
  logic       b_ready, b_sel, b_busy;
  logic [1:0] b_out_valid;
  logic [7:0] b_out_data;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  demux_burst_sched #(.DATA_W(8), .BURST_LEN(4)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dest(in_dest), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .sel(sel), .busy(busy)
  );

  demux_burst_sched #(.DATA_W(8), .BURST_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .mode(b_mode), .in_valid(b_valid), .in_ready(b_ready),
    .in_data(b_data), .in_dest(b_dest), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .sel(b_sel), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic dest, input logic m);
    in_valid = 1'b1;
    in_data  = d;
    in_dest  = dest;
    mode     = m;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_word(input string tag, input logic [1:0] v, input logic [7:0] d,
                          input logic s, input logic b);
    chk({tag, "_valid"}, 32'(out_valid), 32'(v));
    chk({tag, "_data"},  32'(out_data),  32'(d));
    chk({tag, "_sel"},   32'(sel),       32'(s));
    chk({tag, "_busy"},  32'(busy),      32'(b));
  endtask

  task automatic burst(input string tag, input logic [7:0] base, input logic m,
                       input logic dest, input logic exp_ch);
    for (int i = 0; i < 4; i++) begin
      send(base + 8'(i), dest, m);
      chk_word(tag, exp_ch ? 2'b10 : 2'b01, base + 8'(i), exp_ch, (i != 3));
    end
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_dest = 1'b0; in_data = 8'h00;
    out_ready = 2'b11;
    b_mode = 1'b1; b_valid = 1'b0; b_dest = 1'b0; b_data = 8'h00; b_out_ready = 2'b11;
    tick(); tick();
    rst = 1'b0;
    chk_word("reset", 2'b00, 8'h00, 1'b0, 1'b0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    // dest-directed burst to channel 1
    for (int i = 0; i < 4; i++) begin
      send(8'h11 + 8'(i), 1'b1, 1'b0);
      chk_word("m0_d1", 2'b10, 8'h11 + 8'(i), 1'b1, (i != 3));
    end
    tick();
    chk_word("m0_drain", 2'b00, 8'h14, 1'b1, 1'b0);

    // in_dest toggling mid-burst is ignored; next burst follows with no bubble
    for (int i = 0; i < 4; i++) begin
      send(8'h21 + 8'(i), 1'(i & 1), 1'b0);
      chk_word("toggle", 2'b01, 8'h21 + 8'(i), 1'b0, (i != 3));
    end
    in_valid = 1'b1; in_dest = 1'b1; #1;
    chk("b2b_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      send(8'h31 + 8'(i), ~1'(i & 1), 1'b0);
      chk_word("b2b", 2'b10, 8'h31 + 8'(i), 1'b1, (i != 3));
    end

    // round-robin with an inserted dest-directed burst
    burst("rr_a", 8'h41, 1'b1, 1'b1, 1'b0);
    burst("ins",  8'h45, 1'b0, 1'b0, 1'b0);
    burst("rr_b", 8'h49, 1'b1, 1'b0, 1'b1);
    burst("rr_c", 8'h4d, 1'b1, 1'b1, 1'b0);
    chk("rr_ptr_after", 32'(dut.rr_ptr), 32'd1);
    tick();

    // stall on channel 0 mid-burst
    send(8'h51, 1'b0, 1'b0);
    send(8'h52, 1'b1, 1'b0);
    out_ready = 2'b10;
    in_valid = 1'b1; in_data = 8'h53; #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      tick();
      chk_word("stall", 2'b01, 8'h52, 1'b0, 1'b1);
    end
    out_ready = 2'b11; #1;
    chk("resume_in_ready", 32'(in_ready), 32'd1);
    send(8'h53, 1'b1, 1'b0);
    chk_word("resume3", 2'b01, 8'h53, 1'b0, 1'b1);
    send(8'h54, 1'b1, 1'b0);
    chk_word("resume4", 2'b01, 8'h54, 1'b0, 1'b0);
    tick();

    // reset mid-burst drops the partial burst
    send(8'h61, 1'b1, 1'b0);
    send(8'h62, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_word("mid_rst", 2'b00, 8'h00, 1'b0, 1'b0);
    send(8'h71, 1'b1, 1'b0);
    chk_word("post_rst", 2'b10, 8'h71, 1'b1, 1'b1);

    // single-word bursts in round-robin
    for (int i = 0; i < 4; i++) begin
      b_valid = 1'b1; b_data = 8'h81 + 8'(i); b_dest = 1'b1;
      tick();
      b_valid = 1'b0;
      chk("bl1_valid", 32'(b_out_valid), (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("bl1_data",  32'(b_out_data),  32'(8'h81 + 8'(i)));
      chk("bl1_busy",  32'(b_busy),      32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
